uart_tx_fifo_param: RTL and testbench

//  Parametrised UART transmitter. Successor to the fixed 8N1, 2-clk/bit TX.
//  - Configurable data width, baud divider, parity mode and stop-bit count.
//  - Internal write FIFO with valid/ready input handshake, so frames go out back-to-back.
//  - Sits between a byte producer (CPU bridge, test pattern gen) and the board TX pin.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_sync_fifo.sv | 61 ++++++
 rtl/uart_tx_fifo_param.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_fifo_param.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART blocks: parity mode codes, transmitter
//   FSM state encoding and a helper that turns a clock/baud pair into a
//   CLKS_PER_BIT value.
//   No ports (package).
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_e;

  // Rounded clock-cycles-per-bit for a given system clock and baud rate,
  // e.g. baud_divider(100_000_000, 115_200) = 868.
  function automatic int baud_divider(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo
//   Single-clock FIFO with show-ahead read data, shared by the UART TX and RX.
//   Ports:
//     clk, reset_p      clock, asynchronous active-low reset (empties FIFO)
//     push, push_data   write request and word; ignored while full
//     pop, pop_data     read request; pop_data always shows the oldest word
//     full, empty       status flags derived from count
//     count             number of stored words, 0..DEPTH
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_p,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == (AW + 1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // Storage array; no reset needed since count guards every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two; a simultaneous
  // push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge reset_p) begin
    if (!reset_p) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// uart_tx_fifo_param
//   Parametrised UART transmitter with an input FIFO so queued words leave
//   back-to-back. Frame: start(0), DATA_BITS LSB first, optional parity,
//   STOP_BITS stop bits (1), each bit CLKS_PER_BIT clocks long.
//   Ports:
//     clk, reset_p  clock, asynchronous active-low reset (aborts any frame)
//     data_i, valid word to send; written when valid && ready at a rising edge
//     ready         FIFO can accept a word
//     tx            registered serial line, idle high
//     busy          frame in flight or FIFO not empty
//     frame_done    one-cycle pulse after the final stop-bit clock
module uart_tx_fifo_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset_p,
  input  logic [DATA_BITS-1:0] data_i,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  tx_state_e            state;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_bit;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_data;
  logic [CNT_W-1:0]     fifo_count;

  logic                 bit_end;
  logic                 frame_end;

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] w);
    return (PARITY == PARITY_ODD) ? ~^w : ^w;
  endfunction

  assign ready     = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign fifo_push = valid && !fifo_full;
  assign busy      = (state != S_IDLE) || !fifo_empty;
  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign frame_end = (state == S_STOP) && bit_end && (bit_cnt == STOP_LAST);
  // Pop from IDLE, or on the last stop clock so the next start bit follows
  // with no idle gap.
  assign fifo_pop  = !fifo_empty && ((state == S_IDLE) || frame_end);

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_p   (reset_p),
    .push      (fifo_push),
    .push_data (data_i),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Transmit FSM. The baud counter runs in every bit state and clears on each
  // bit boundary; bit_cnt indexes data bits and is then reused for stop bits.
  // The data word is consumed from the shift register LSB first.
  always_ff @(posedge clk or negedge reset_p) begin
    if (!reset_p) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tx         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state != S_IDLE) baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          if (fifo_pop) begin
            shift_reg  <= fifo_data;
            parity_bit <= calc_parity(fifo_data);
            tx         <= 1'b0;
            state      <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            tx        <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            state     <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              if (PARITY != PARITY_NONE) begin
                tx    <= parity_bit;
                state <= S_PARITY;
              end else begin
                tx    <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              bit_cnt   <= bit_cnt + 1'b1;
              tx        <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            tx    <= 1'b1;
            state <= S_STOP;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (bit_cnt == STOP_LAST) begin
              bit_cnt    <= '0;
              frame_done <= 1'b1;
              if (fifo_pop) begin
                shift_reg  <= fifo_data;
                parity_bit <= calc_parity(fifo_data);
                tx         <= 1'b0;
                state      <= S_START;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// tb_uart_tx_fifo_param
//   Drives three transmitter configurations (8N1 depth 16, 7E2 depth 4,
//   7O1 depth 4) with directed and random words. A per-instance monitor
//   rebuilds each expected frame from the queued word and checks the line
//   mid-bit, the frame_done pulse, busy, back-to-back starts and ready.
module tb_uart_tx_fifo_param;

  localparam int C    = 4;
  localparam int NDUT = 3;

  logic            clk = 1'b0;
  logic            reset_p;
  logic [7:0]      data0;
  logic [6:0]      data1;
  logic [6:0]      data2;
  logic [NDUT-1:0] valid_w;
  logic [NDUT-1:0] ready_w;
  logic [NDUT-1:0] tx_w;
  logic [NDUT-1:0] busy_w;
  logic [NDUT-1:0] fd_w;

  int     n_vec  = 0;
  int     n_err  = 0;
  int     edge_n = 0;
  longint sb [NDUT][$];
  bit     inframe [NDUT];

  always #5 clk = ~clk;

  // Edge counter used to time-stamp accepted words.
  always @(posedge clk) edge_n <= edge_n + 1;

  uart_tx_fifo_param #(.DATA_BITS(8), .CLKS_PER_BIT(C), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) dut0 (
    .clk(clk), .reset_p(reset_p), .data_i(data0), .valid(valid_w[0]), .ready(ready_w[0]),
    .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(fd_w[0]));

  uart_tx_fifo_param #(.DATA_BITS(7), .CLKS_PER_BIT(C), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .reset_p(reset_p), .data_i(data1), .valid(valid_w[1]), .ready(ready_w[1]),
    .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(fd_w[1]));

  uart_tx_fifo_param #(.DATA_BITS(7), .CLKS_PER_BIT(C), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .reset_p(reset_p), .data_i(data2), .valid(valid_w[2]), .ready(ready_w[2]),
    .tx(tx_w[2]), .busy(busy_w[2]), .frame_done(fd_w[2]));

  // Configuration of each instance, as seen by the reference model.
  function automatic int db(input int d);
    return (d == 0) ? 8 : 7;
  endfunction
  function automatic int par(input int d);
    case (d)
      0:       return 0;
      1:       return 1;
      default: return 2;
    endcase
  endfunction
  function automatic int sbits(input int d);
    return (d == 1) ? 2 : 1;
  endfunction
  function automatic int depth(input int d);
    return (d == 0) ? 16 : 4;
  endfunction
  function automatic int frame_bits(input int d);
    return 1 + db(d) + ((par(d) != 0) ? 1 : 0) + sbits(d);
  endfunction

  // Expected line level for frame bit k of word w.
  function automatic logic exp_bit(input int d, input int w, input int k);
    int m;
    int ones;
    m    = w & ((1 << db(d)) - 1);
    ones = $countones(m);
    if (k == 0) return 1'b0;
    if (k <= db(d)) return 1'((m >> (k - 1)) & 1);
    if (par(d) != 0 && k == db(d) + 1)
      return (par(d) == 1) ? 1'(ones % 2) : 1'(1 - ones % 2);
    return 1'b1;
  endfunction

  function automatic int head_stamp(input int d);
    if (sb[d].size() == 0) return 32'h4000_0000;
    return int'(sb[d][0] >>> 16);
  endfunction

  // Words accepted by the FIFO and not yet started on the line.
  function automatic int in_fifo(input int d);
    int n = 0;
    foreach (sb[d][i]) if (int'(sb[d][i] >>> 16) <= edge_n) n++;
    return n;
  endfunction

  task automatic checkOutput(input string tag, input logic obs, input logic expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // Line monitor for one instance; samples on the falling edge.
  task automatic monitor(input int d);
    int off  = 0;
    int word = 0;
    int len;
    bit pend;
    len = frame_bits(d) * C;
    forever begin
      @(negedge clk);
      if (!reset_p) begin
        inframe[d] = 1'b0;
      end else if (!inframe[d]) begin
        pend = head_stamp(d) < edge_n;
        checkOutput($sformatf("d%0d_idle_tx", d), tx_w[d], !pend);
        checkOutput($sformatf("d%0d_idle_busy", d), busy_w[d], head_stamp(d) <= edge_n);
        checkOutput($sformatf("d%0d_idle_fd", d), fd_w[d], 1'b0);
        if (pend && tx_w[d] === 1'b0) begin
          word       = int'(sb[d].pop_front() & 16'hFFFF);
          off        = 0;
          inframe[d] = 1'b1;
        end
      end else begin
        off++;
        if (off == len) begin
          checkOutput($sformatf("d%0d_frame_done", d), fd_w[d], 1'b1);
          pend = head_stamp(d) < edge_n;
          checkOutput($sformatf("d%0d_next_start", d), tx_w[d], !pend);
          if (pend && tx_w[d] === 1'b0) begin
            word = int'(sb[d].pop_front() & 16'hFFFF);
            off  = 0;
          end else begin
            inframe[d] = 1'b0;
          end
        end else begin
          if (off % C == C / 2) begin
            checkOutput($sformatf("d%0d_w%02h_bit%0d", d, word, off / C), tx_w[d], exp_bit(d, word, off / C));
            checkOutput($sformatf("d%0d_busy", d), busy_w[d], 1'b1);
          end
          if (off == len - 1) checkOutput($sformatf("d%0d_fd_early", d), fd_w[d], 1'b0);
        end
      end
    end
  endtask

  // Holds valid with word w until the instance accepts it; expects ready to
  // follow the model's FIFO occupancy every cycle. Entered and left at
  // negedge+1.
  task automatic applyStimulus(input int d, input logic [7:0] w);
    int waited = 0;
    case (d)
      0:       data0 = w;
      1:       data1 = w[6:0];
      default: data2 = w[6:0];
    endcase
    valid_w[d] = 1'b1;
    forever begin
      checkOutput($sformatf("d%0d_ready", d), ready_w[d], in_fifo(d) < depth(d));
      if (ready_w[d] === 1'b1) begin
        sb[d].push_back((longint'(edge_n + 1) << 16) | longint'(w));
        break;
      end
      waited++;
      if (waited > 2000) begin
        n_vec++;
        n_err++;
        $error("[TB] FAIL d%0d_accept_timeout: observed ready=0 expected ready=1", d);
        break;
      end
      @(negedge clk); #1;
    end
    @(negedge clk); #1;
    valid_w[d] = 1'b0;
  endtask

  task automatic drainAll(input string tag);
    int t = 0;
    bit done;
    do begin
      @(negedge clk); #1;
      t++;
      done = 1'b1;
      for (int d = 0; d < NDUT; d++) if (sb[d].size() != 0 || inframe[d]) done = 1'b0;
    end while (!done && t < 4000);
    n_vec++;
    assert (done) else begin
      n_err++;
      $error("[TB] FAIL %s_drain: observed timeout expected all idle", tag);
    end
    for (int d = 0; d < NDUT; d++) checkOutput($sformatf("%s_d%0d_busy_end", tag, d), busy_w[d], 1'b0);
  endtask

  initial begin
    reset_p = 1'b0;
    valid_w = '0;
    data0   = '0;
    data1   = '0;
    data2   = '0;
    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none

    $display("[TB] reset state");
    repeat (3) @(negedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      checkOutput($sformatf("rst_d%0d_tx", d), tx_w[d], 1'b1);
      checkOutput($sformatf("rst_d%0d_busy", d), busy_w[d], 1'b0);
      checkOutput($sformatf("rst_d%0d_ready", d), ready_w[d], 1'b1);
      checkOutput($sformatf("rst_d%0d_fd", d), fd_w[d], 1'b0);
    end
    reset_p = 1'b1;
    @(negedge clk); #1;

    $display("[TB] 8N1 single word 0xA5");
    applyStimulus(0, 8'hA5);
    drainAll("t1");

    $display("[TB] 7-bit even/odd parity, word 0x53");
    applyStimulus(1, 8'h53);
    applyStimulus(2, 8'h53);
    drainAll("t2");

    $display("[TB] two stop bits, 0x7F then 0x00 back to back");
    applyStimulus(1, 8'hFF);
    applyStimulus(1, 8'h00);
    drainAll("t3");

    $display("[TB] fill 16-deep FIFO with 20 words");
    for (int i = 0; i < 20; i++) applyStimulus(0, 8'($urandom_range(0, 255)));
    drainAll("t4");

    $display("[TB] reset during data bit 3");
    applyStimulus(0, 8'h96);
    repeat (18) @(negedge clk);
    #1;
    checkOutput("rst_mid_busy_before", busy_w[0], 1'b1);
    reset_p = 1'b0;
    for (int d = 0; d < NDUT; d++) sb[d].delete();
    #1;
    checkOutput("rst_mid_tx", tx_w[0], 1'b1);
    checkOutput("rst_mid_busy", busy_w[0], 1'b0);
    checkOutput("rst_mid_ready", ready_w[0], 1'b1);
    repeat (3) @(negedge clk);
    #1;
    reset_p = 1'b1;
    @(negedge clk); #1;
    applyStimulus(0, 8'h3C);
    drainAll("t5");

    $display("[TB] random words with valid held through back-pressure");
    for (int i = 0; i < 40; i++) begin
      applyStimulus($urandom_range(0, NDUT - 1), 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk); #1;
      end
    end
    drainAll("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
